// File: rtl/frame_rr_arbiter.sv
// Burst-locked round-robin arbiter feeding the processing-input FIFO from two slave sources.
// A grant is held until the source's last beat, a MAX_BURST-beat limit, or an abandoned request.
module frame_rr_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slv0_req,
    input  logic [1:0]    slv0_mode,
    input  logic [DW-1:0] slv0_data,
    input  logic [7:0]    slv0_proc_val,
    input  logic          slv0_data_valid,
    input  logic          slv0_last,
    output logic          slv0_ready,
    input  logic          slv1_req,
    input  logic [1:0]    slv1_mode,
    input  logic [DW-1:0] slv1_data,
    input  logic [7:0]    slv1_proc_val,
    input  logic          slv1_data_valid,
    input  logic          slv1_last,
    output logic          slv1_ready,
    input  logic          fifo_full,
    input  logic          mstr_cmplt,
    output logic [1:0]    slvx_mode,
    output logic [DW-1:0] slvx_data,
    output logic [7:0]    slvx_proc_val,
    output logic          slvx_data_valid,
    output logic          slvx_last,
    output logic [1:0]    grant,
    output logic          busy
);

    localparam int unsigned CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          last_served;

    logic          cur_req;
    logic          cur_valid;
    logic          cur_last;
    logic [1:0]    cur_mode;
    logic [DW-1:0] cur_data;
    logic [7:0]    cur_proc_val;
    logic          accept;
    logic          at_limit;
    logic          burst_end;
    logic          abandon;

    // Mux the granted source onto the shared beat path; readies track FIFO space for the owner only.
    always_comb begin
        cur_req      = 1'b0;
        cur_valid    = 1'b0;
        cur_last     = 1'b0;
        cur_mode     = 2'd0;
        cur_data     = '0;
        cur_proc_val = 8'd0;
        slv0_ready   = 1'b0;
        slv1_ready   = 1'b0;
        case (state)
            GNT0: begin
                cur_req      = slv0_req;
                cur_valid    = slv0_data_valid;
                cur_last     = slv0_last;
                cur_mode     = slv0_mode;
                cur_data     = slv0_data;
                cur_proc_val = slv0_proc_val;
                slv0_ready   = ~fifo_full;
            end
            GNT1: begin
                cur_req      = slv1_req;
                cur_valid    = slv1_data_valid;
                cur_last     = slv1_last;
                cur_mode     = slv1_mode;
                cur_data     = slv1_data;
                cur_proc_val = slv1_proc_val;
                slv1_ready   = ~fifo_full;
            end
            default: ;
        endcase
    end

    assign accept    = cur_valid & ~fifo_full;
    assign at_limit  = (count == CNT_LIMIT);
    assign burst_end = accept & (cur_last | at_limit);
    assign abandon   = (state != IDLE) & ~cur_req & ~accept;

    // Arbitration state, beat counter and registered FIFO write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            last_served     <= 1'b1;
            grant           <= 2'b00;
            busy            <= 1'b0;
            slvx_mode       <= 2'd0;
            slvx_data       <= '0;
            slvx_proc_val   <= 8'd0;
            slvx_data_valid <= 1'b0;
            slvx_last       <= 1'b0;
        end else begin
            slvx_data_valid <= accept;
            if (accept) begin
                slvx_mode     <= cur_mode;
                slvx_data     <= cur_data;
                slvx_proc_val <= cur_proc_val;
                slvx_last     <= cur_last | at_limit;
            end

            case (state)
                IDLE: begin
                    if (!mstr_cmplt && (slv0_req || slv1_req)) begin
                        // slv0 wins alone, or on a tie when slv1 was served last
                        if (slv0_req && (!slv1_req || last_served)) begin
                            state <= GNT0;
                            grant <= 2'b01;
                        end else begin
                            state <= GNT1;
                            grant <= 2'b10;
                        end
                        busy  <= 1'b1;
                        count <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (burst_end || abandon) begin
                        state       <= IDLE;
                        grant       <= 2'b00;
                        busy        <= 1'b0;
                        count       <= '0;
                        last_served <= (state == GNT1);
                    end else if (accept) begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Directed bench for frame_rr_arbiter with MAX_BURST=4: round-robin, back-pressure,
// forced release, mstr_cmplt gating, abandon and mid-burst reset.
module tb_frame_rr_arbiter;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          slv0_req, slv0_data_valid, slv0_last, slv0_ready;
    logic [1:0]    slv0_mode;
    logic [DW-1:0] slv0_data;
    logic [7:0]    slv0_proc_val;
    logic          slv1_req, slv1_data_valid, slv1_last, slv1_ready;
    logic [1:0]    slv1_mode;
    logic [DW-1:0] slv1_data;
    logic [7:0]    slv1_proc_val;
    logic          fifo_full, mstr_cmplt;
    logic [1:0]    slvx_mode;
    logic [DW-1:0] slvx_data;
    logic [7:0]    slvx_proc_val;
    logic          slvx_data_valid, slvx_last;
    logic [1:0]    grant;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    frame_rr_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .slv0_req(slv0_req), .slv0_mode(slv0_mode), .slv0_data(slv0_data),
        .slv0_proc_val(slv0_proc_val), .slv0_data_valid(slv0_data_valid),
        .slv0_last(slv0_last), .slv0_ready(slv0_ready),
        .slv1_req(slv1_req), .slv1_mode(slv1_mode), .slv1_data(slv1_data),
        .slv1_proc_val(slv1_proc_val), .slv1_data_valid(slv1_data_valid),
        .slv1_last(slv1_last), .slv1_ready(slv1_ready),
        .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt),
        .slvx_mode(slvx_mode), .slvx_data(slvx_data), .slvx_proc_val(slvx_proc_val),
        .slvx_data_valid(slvx_data_valid), .slvx_last(slvx_last),
        .grant(grant), .busy(busy)
    );

    // Beat pattern: id tag on top, index in proc_val bits and mode bits.
    function automatic logic [DW-1:0] bv(input logic [7:0] id, input logic [3:0] i);
        return {id, 8'h5A, 4'h0, i, 6'h00, i[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s0(input logic req, input logic v, input logic [DW-1:0] d, input logic l);
        slv0_req = req; slv0_data_valid = v; slv0_data = d; slv0_last = l;
        slv0_mode = d[1:0]; slv0_proc_val = d[15:8];
    endtask

    task automatic s1(input logic req, input logic v, input logic [DW-1:0] d, input logic l);
        slv1_req = req; slv1_data_valid = v; slv1_data = d; slv1_last = l;
        slv1_mode = d[1:0]; slv1_proc_val = d[15:8];
    endtask

    task automatic out_beat(input string tag, input logic [DW-1:0] d, input logic l);
        chk({tag, "_dv"}, 64'(slvx_data_valid), 64'(1'b1));
        chk({tag, "_data"}, 64'(slvx_data), 64'(d));
        chk({tag, "_mode"}, 64'(slvx_mode), 64'(d[1:0]));
        chk({tag, "_pv"}, 64'(slvx_proc_val), 64'(d[15:8]));
        chk({tag, "_last"}, 64'(slvx_last), 64'(l));
    endtask

    task automatic out_idle(input string tag, input logic [DW-1:0] d, input logic l);
        chk({tag, "_dv"}, 64'(slvx_data_valid), 64'(1'b0));
        chk({tag, "_hold"}, 64'(slvx_data), 64'(d));
        chk({tag, "_hlast"}, 64'(slvx_last), 64'(l));
    endtask

    task automatic st(input string tag, input logic [1:0] g, input logic b);
        chk({tag, "_grant"}, 64'(grant), 64'(g));
        chk({tag, "_busy"}, 64'(busy), 64'(b));
    endtask

    task automatic rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, "_rdy0"}, 64'(slv0_ready), 64'(r0));
        chk({tag, "_rdy1"}, 64'(slv1_ready), 64'(r1));
    endtask

    initial begin
        rst = 1'b1; fifo_full = 1'b0; mstr_cmplt = 1'b0;
        s0(0, 0, '0, 0);
        s1(0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1;
        st("rst", 2'b00, 0);
        out_idle("rst", '0, 0);
        rdy("rst", 0, 0);

        // Both request 3-beat bursts: slv0 first, one IDLE cycle, then slv1
        rst = 1'b0;
        s0(1, 1, bv(8'hA0, 0), 0);
        s1(1, 1, bv(8'hB0, 0), 0);
        rdy("t1_idle", 0, 0);
        tick(); st("t1_g0", 2'b01, 1); out_idle("t1_g0", '0, 0); rdy("t1_g0", 1, 0);
        tick(); out_beat("t1_a0", bv(8'hA0, 0), 0); s0(1, 1, bv(8'hA0, 1), 0);
        tick(); out_beat("t1_a1", bv(8'hA0, 1), 0); s0(1, 1, bv(8'hA0, 2), 1);
        tick(); out_beat("t1_a2", bv(8'hA0, 2), 1); st("t1_rel", 2'b00, 0);
        s0(0, 0, '0, 0); rdy("t1_rel", 0, 0);
        tick(); st("t1_g1", 2'b10, 1); out_idle("t1_g1", bv(8'hA0, 2), 1); rdy("t1_g1", 0, 1);
        tick(); out_beat("t1_b0", bv(8'hB0, 0), 0); s1(1, 1, bv(8'hB0, 1), 0);
        tick(); out_beat("t1_b1", bv(8'hB0, 1), 0); s1(1, 1, bv(8'hB0, 2), 1);
        tick(); out_beat("t1_b2", bv(8'hB0, 2), 1); st("t1_end", 2'b00, 0);
        s1(0, 0, '0, 0);

        // slv0 4-beat burst with two cycles of fifo_full after beat 0
        s0(1, 1, bv(8'hC0, 0), 0);
        tick(); st("t2_g0", 2'b01, 1); out_idle("t2_g0", bv(8'hB0, 2), 1);
        tick(); out_beat("t2_c0", bv(8'hC0, 0), 0); s0(1, 1, bv(8'hC0, 1), 0);
        fifo_full = 1'b1; rdy("t2_full", 0, 0);
        tick(); out_idle("t2_full1", bv(8'hC0, 0), 0); st("t2_hold", 2'b01, 1);
        tick(); out_idle("t2_full2", bv(8'hC0, 0), 0); fifo_full = 1'b0; rdy("t2_resume", 1, 0);
        tick(); out_beat("t2_c1", bv(8'hC0, 1), 0); s0(1, 1, bv(8'hC0, 2), 0);
        tick(); out_beat("t2_c2", bv(8'hC0, 2), 0); s0(1, 1, bv(8'hC0, 3), 1);
        tick(); out_beat("t2_c3", bv(8'hC0, 3), 1); st("t2_end", 2'b00, 0);

        // slv0 6-beat burst forced out after 4 beats, slv1 served, slv0 resumes
        s0(1, 1, bv(8'hE0, 0), 0);
        tick(); st("t3_g0", 2'b01, 1); out_idle("t3_g0", bv(8'hC0, 3), 1);
        s1(1, 1, bv(8'hF0, 0), 1); rdy("t3_g0", 1, 0);
        tick(); out_beat("t3_e0", bv(8'hE0, 0), 0); s0(1, 1, bv(8'hE0, 1), 0);
        tick(); out_beat("t3_e1", bv(8'hE0, 1), 0); s0(1, 1, bv(8'hE0, 2), 0);
        tick(); out_beat("t3_e2", bv(8'hE0, 2), 0); s0(1, 1, bv(8'hE0, 3), 0);
        tick(); out_beat("t3_e3", bv(8'hE0, 3), 1); st("t3_forced", 2'b00, 0);
        s0(1, 1, bv(8'hE0, 4), 0); rdy("t3_forced", 0, 0);
        tick(); st("t3_g1", 2'b10, 1); out_idle("t3_g1", bv(8'hE0, 3), 1); rdy("t3_g1", 0, 1);
        tick(); out_beat("t3_f0", bv(8'hF0, 0), 1); st("t3_rel1", 2'b00, 0); s1(0, 0, '0, 0);
        tick(); st("t3_regnt", 2'b01, 1); out_idle("t3_regnt", bv(8'hF0, 0), 1);
        tick(); out_beat("t3_e4", bv(8'hE0, 4), 0); s0(1, 1, bv(8'hE0, 5), 1);
        tick(); out_beat("t3_e5", bv(8'hE0, 5), 1); st("t3_end", 2'b00, 0);

        // mstr_cmplt rises mid-burst: burst finishes, new grants wait for it to fall
        s0(1, 1, bv(8'h60, 0), 0);
        tick(); st("t4_g0", 2'b01, 1);
        tick(); out_beat("t4_g0b", bv(8'h60, 0), 0); s0(1, 1, bv(8'h60, 1), 0); mstr_cmplt = 1'b1;
        tick(); out_beat("t4_g1b", bv(8'h60, 1), 0); s0(1, 1, bv(8'h60, 2), 1);
        tick(); out_beat("t4_g2b", bv(8'h60, 2), 1); st("t4_rel", 2'b00, 0);
        s0(1, 1, bv(8'h70, 0), 1); s1(1, 1, bv(8'h80, 0), 1);
        tick(); st("t4_blk1", 2'b00, 0); out_idle("t4_blk1", bv(8'h60, 2), 1);
        tick(); st("t4_blk2", 2'b00, 0); mstr_cmplt = 1'b0;
        tick(); st("t4_gnt", 2'b10, 1); out_idle("t4_gnt", bv(8'h60, 2), 1);

        // slv1 abandons its grant with no beat: no strobe, slv0 granted next
        s1(0, 0, '0, 0); rdy("t5_abn", 0, 1);
        tick(); st("t5_idle", 2'b00, 0); out_idle("t5_idle", bv(8'h60, 2), 1);
        tick(); st("t5_g0", 2'b01, 1); out_idle("t5_g0", bv(8'h60, 2), 1);
        tick(); out_beat("t5_h0", bv(8'h70, 0), 1); st("t5_end", 2'b00, 0);

        // Reset mid-burst clears outputs at once; slv0 wins the first tie afterwards
        s0(1, 1, bv(8'h90, 0), 0);
        tick(); st("t6_g0", 2'b01, 1);
        tick(); out_beat("t6_m0", bv(8'h90, 0), 0); s0(1, 1, bv(8'h90, 1), 0);
        #1 rst = 1'b1;
        #1; st("t6_rst", 2'b00, 0); out_idle("t6_rst", '0, 0); rdy("t6_rst", 0, 0);
        tick(); out_idle("t6_rhold", '0, 0);
        rst = 1'b0;
        s0(1, 1, bv(8'hD0, 0), 0); s1(1, 1, bv(8'hD1, 0), 0);
        tick(); st("t6_tie", 2'b01, 1); out_idle("t6_tie", '0, 0); rdy("t6_tie", 1, 0);
        tick(); out_beat("t6_n0", bv(8'hD0, 0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_rr_arbiter.md
Name: frame_rr_arbiter

Overview:
- Burst-locked round-robin arbiter sharing the processing-input FIFO between two slave sources, slv0 and slv1.
- Grant is held for a whole burst, ending on slvN_last or on MAX_BURST beats, so one source's frame data never interleaves with the other's.
- Output is a registered beat stream (mode, data, proc_val, last) into the FIFO write side, throttled by fifo_full; new grants are gated by mstr_cmplt.

Parameters:
DW, 32, data beat width
MAX_BURST, 64, max beats per grant before forced release (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
slv0_req  input  1  slv0 requests a burst
slv0_mode  input  2  slv0 processing mode
slv0_data  input  DW  slv0 data beat
slv0_proc_val  input  8  slv0 processing value
slv0_data_valid  input  1  slv0 beat valid
slv0_last  input  1  slv0 final beat of burst
slv0_ready  output  1  slv0 beat accepted when valid&ready
slv1_req, slv1_mode, slv1_data, slv1_proc_val, slv1_data_valid, slv1_last, slv1_ready  as slv0
fifo_full  input  1  FIFO cannot accept a write
mstr_cmplt  input  1  master completion; blocks new grants
slvx_mode  output  2  registered mode of accepted beat
slvx_data  output  DW  registered data
slvx_proc_val  output  8  registered proc value
slvx_data_valid  output  1  one-cycle FIFO write strobe
slvx_last  output  1  burst-end marker, qualified by slvx_data_valid
grant  output  2  one-hot current owner (bit0 slv0)
busy  output  1  state != IDLE

Behaviour:
- Reset (rst high, async): state IDLE, grant 0, all slvx_* 0, slvN_ready 0, beat counter 0, last_served=slv1 so slv0 wins the first tie. Mid-burst reset drops the burst with no trailing last.
- States: IDLE, GNT0, GNT1.
- IDLE, transitions:
  - mstr_cmplt=0 and any slvN_req: move to GNTn next cycle.
  - Both requesting: pick the source that is not last_served.
  - mstr_cmplt=1: stay in IDLE.
- Ready: in GNTn, slvN_ready = ~fifo_full (combinational). Non-granted ready is always 0; both readies are 0 in IDLE.
- Accept: slvN_data_valid & slvN_ready. On the following cycle:
  - slvx_data_valid=1.
  - slvx_mode/data/proc_val carry the accepted beat.
  - slvx_last = slvN_last | (count==MAX_BURST-1).
- Latency: accept at cycle T, write strobe at T+1. Sustained throughput is one beat per cycle.
- When no beat is accepted: slvx_data_valid=0; slvx_mode/data/proc_val/last hold their previous values.
- Beat counter: increments per accepted beat and clears on burst end.
- Burst end (accepted beat with slvN_last, or count==MAX_BURST-1): go to IDLE next cycle, last_served=N, counter cleared. Every re-arbitration costs exactly one IDLE cycle.
- MAX_BURST release: after a forced release the source re-requests and rejoins round-robin. A forced release is indistinguishable downstream from a real last.
- fifo_full=1 in GNTn: ready low, state and counter held, no beats lost or duplicated.
- slvN_req low in GNTn with no beat accepted that cycle (abandon): go to IDLE, counter cleared, last_served=N, no slvx_last emitted.
- mstr_cmplt=1 during GNTn: current burst completes normally; only new grants are blocked.
- valid with last on the same beat as the MAX_BURST limit: a single end, slvx_last=1.
- grant and busy are registered with state; grant is one-hot or zero.

Test Plan:
- Reset release, slv0 and slv1 both request 3-beat bursts (A0..A2 / B0..B2), fifo_full=0 -> grant=01, A0..A2 written on consecutive cycles T+1..T+3 with slvx_last on A2, one IDLE cycle, grant=10, B0..B2 with last on B2.
- slv0 burst of 4, fifo_full high for 2 cycles after beat 1 -> slv0_ready low those cycles, exactly 4 strobes with data in order, no duplicate, counter resumes.
- MAX_BURST=4, slv0 6-beat burst with slv1 requesting -> slvx_last on slv0's 4th beat, slv1 burst served, then slv0 regranted for the remaining 2 beats.
- mstr_cmplt raised during GNT0 beat 2 of 3 -> beat 3 and its last still written; IDLE held, no grant while mstr_cmplt=1; grant issued the cycle after it falls.
- GNT1 with slv1_req dropped and no valid -> IDLE next cycle, no strobe, slv0 (requesting) granted next.
- rst pulsed mid-burst in GNT0 -> all outputs 0 immediately, no further strobes; after release a simultaneous request grants slv0 first.
